// File: rtl/jtsdram_bank_sched.sv
// Read-test scheduler for the four JTSDRAM bank ports.
// Ports: clk/rst, start/halt/bank_en control, baN_addr/rd/ack/rdy bank
// handshakes, shared data_read, and busy/done/bad/err_cnt/timeout status.
module jtsdram_bank_sched #(
  parameter int AW      = 22,
  parameter int BURST   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          halt,
  input  logic [3:0]    bank_en,
  output logic [AW-1:0] ba0_addr,
  output logic [AW-1:0] ba1_addr,
  output logic [AW-1:0] ba2_addr,
  output logic [AW-1:0] ba3_addr,
  output logic          ba0_rd,
  output logic          ba1_rd,
  output logic          ba2_rd,
  output logic          ba3_rd,
  input  logic          ba0_ack,
  input  logic          ba1_ack,
  input  logic          ba2_ack,
  input  logic          ba3_ack,
  input  logic          ba0_rdy,
  input  logic          ba1_rdy,
  input  logic          ba2_rdy,
  input  logic          ba3_rdy,
  input  logic [31:0]   data_read,
  output logic          busy,
  output logic          done,
  output logic          bad,
  output logic [7:0]    err_cnt,
  output logic          timeout
);

  typedef enum logic [2:0] {
    IDLE, SELECT, REQ, WAIT, DONE
  } state_t;

  state_t state, nxt;

  logic [3:0]    mask;
  logic [AW-1:0] ptr [4];
  logic [7:0]    cnt [4];
  logic [1:0]    last, cur;
  logic [7:0]    tcnt;

  logic [3:0]  ack, rdy, elig;
  logic [1:0]  pick, cand;
  logic        pick_ok;
  logic [15:0] a16;
  logic [31:0] exp_word;
  logic        finish, abort, err_inc;

  assign ack = {ba3_ack, ba2_ack, ba1_ack, ba0_ack};
  assign rdy = {ba3_rdy, ba2_rdy, ba1_rdy, ba0_rdy};

  assign ba0_addr = ptr[0];
  assign ba1_addr = ptr[1];
  assign ba2_addr = ptr[2];
  assign ba3_addr = ptr[3];

  always_comb begin
    for (int b = 0; b < 4; b++)
      elig[b] = mask[b] && (cnt[b] < 8'(BURST));
  end

  // Round-robin: first eligible bank strictly after last,
  // with last itself considered only at the end.
  always_comb begin
    pick_ok = 1'b0;
    pick    = last;
    cand    = last;
    for (int i = 1; i <= 4; i++) begin
      cand = last + 2'(i);
      if (!pick_ok && elig[cand]) begin
        pick_ok = 1'b1;
        pick    = cand;
      end
    end
  end

  assign a16      = ptr[cur][15:0];
  assign exp_word = {a16 ^ {cur, 14'd0}, ~a16};

  always_comb begin
    finish = 1'b0;
    unique case (1'b1)
      state == REQ:  finish = ack[cur] && rdy[cur];
      state == WAIT: finish = rdy[cur];
      default:       finish = 1'b0;
    endcase
  end

  assign abort   = (state == REQ || state == WAIT) && !finish &&
                   (tcnt == 8'(TIMEOUT));
  assign err_inc = abort || (finish && data_read != exp_word);

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start && !halt) nxt = SELECT;
      SELECT:  nxt = pick_ok ? REQ : DONE;
      REQ: begin
        if (finish || abort) nxt = SELECT;
        else if (ack[cur])   nxt = WAIT;
      end
      WAIT:    if (finish || abort) nxt = SELECT;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 4; b++) begin
        ptr[b] <= '0;
        cnt[b] <= '0;
      end
      mask    <= '0;
      last    <= 2'd3;
      cur     <= 2'd0;
      tcnt    <= '0;
      bad     <= 1'b0;
      timeout <= 1'b0;
      err_cnt <= '0;
    end else begin
      if (state == IDLE && start && !halt) begin
        mask    <= bank_en;
        err_cnt <= '0;
        for (int b = 0; b < 4; b++) cnt[b] <= '0;
      end
      if (state == SELECT) begin
        cur  <= pick;
        tcnt <= '0;
      end
      if (state == REQ || state == WAIT)
        tcnt <= tcnt + 8'd1;
      // A timeout retires the read just like a completion.
      if (finish || abort) begin
        ptr[cur] <= ptr[cur] + AW'(2);
        cnt[cur] <= cnt[cur] + 8'd1;
        last     <= cur;
      end
      if (err_inc) begin
        bad <= 1'b1;
        if (err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
      end
      if (abort) timeout <= 1'b1;
    end
  end

  assign busy   = (state == SELECT) || (state == REQ) || (state == WAIT);
  assign done   = (state == DONE);
  assign ba0_rd = (state == REQ) && (cur == 2'd0);
  assign ba1_rd = (state == REQ) && (cur == 2'd1);
  assign ba2_rd = (state == REQ) && (cur == 2'd2);
  assign ba3_rd = (state == REQ) && (cur == 2'd3);

endmodule

// File: tb/tb_jtsdram_bank_sched.sv
// Bench for jtsdram_bank_sched: bank responder model plus
// directed passes with hand-computed read order and addresses.
module tb_jtsdram_bank_sched;
  localparam int AW  = 22;
  localparam int BST = 4;
  localparam int TMO = 20;

  logic clk = 0, rst = 1, start = 0, halt = 0;
  logic [3:0] bank_en = 0;
  logic [AW-1:0] a0, a1, a2, a3;
  logic r0, r1, r2, r3;
  logic [3:0] ack_v = 0, rdy_v = 0;
  logic [31:0] data_read = 0;
  logic busy, done, bad, timeout;
  logic [7:0] err_cnt;

  always #5 clk = ~clk;

  jtsdram_bank_sched #(.AW(AW), .BURST(BST), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt),
    .bank_en(bank_en),
    .ba0_addr(a0), .ba1_addr(a1), .ba2_addr(a2), .ba3_addr(a3),
    .ba0_rd(r0), .ba1_rd(r1), .ba2_rd(r2), .ba3_rd(r3),
    .ba0_ack(ack_v[0]), .ba1_ack(ack_v[1]),
    .ba2_ack(ack_v[2]), .ba3_ack(ack_v[3]),
    .ba0_rdy(rdy_v[0]), .ba1_rdy(rdy_v[1]),
    .ba2_rdy(rdy_v[2]), .ba3_rdy(rdy_v[3]),
    .data_read(data_read),
    .busy(busy), .done(done), .bad(bad),
    .err_cnt(err_cnt), .timeout(timeout)
  );

  wire [3:0] rd = {r3, r2, r1, r0};

  int n_tot = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  int ack_d [4] = '{2, 2, 2, 2};
  int rdy_d [4] = '{5, 5, 5, 5};
  int nordy = -1, corrupt = -1;
  bit spur = 0;

  logic [3:0] prev = 0;
  bit act = 0;
  int bk = 0, age = 0, nread = 0, n_done = 0, n_multi = 0;
  logic [AW-1:0] cur_a = 0;
  int lb [$];
  int la [$];
  int eb [$];
  int ea [$];

  function automatic logic [31:0] pat(input int b, input logic [AW-1:0] a);
    logic [15:0] x;
    logic [1:0] bb;
    x  = a[15:0];
    bb = 2'(b);
    return {x ^ {bb, 14'd0}, ~x};
  endfunction

  function automatic logic [AW-1:0] addr_of(input int b);
    case (b)
      0: return a0;
      1: return a1;
      2: return a2;
      default: return a3;
    endcase
  endfunction

  always @(negedge clk) begin
    logic [3:0] rise, av, rv;
    av = 0;
    rv = 0;
    rise = rd & ~prev;
    prev = rd;
    if ($countones(rd) > 1) n_multi++;
    if (done) n_done++;
    if (rise != 0) begin
      act = 1;
      age = 0;
      bk = rise[0] ? 0 : rise[1] ? 1 : rise[2] ? 2 : 3;
      cur_a = addr_of(bk);
      lb.push_back(bk);
      la.push_back(int'(cur_a));
      nread++;
    end else if (act) age++;
    if (act) begin
      if (spur && bk == 0 && age == 2) begin
        rv[3] = 1;
        data_read = 32'hdead_beef;
      end
      if (age == ack_d[bk]) av[bk] = 1;
      if (age == rdy_d[bk] && bk != nordy) begin
        rv[bk] = 1;
        data_read = pat(bk, cur_a) ^ ((nread == corrupt) ? 32'd1 : 32'd0);
        act = 0;
      end
    end
    ack_v = av;
    rdy_v = rv;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic kick(input logic [3:0] en);
    lb.delete();
    la.delete();
    nread = 0;
    n_done = 0;
    bank_en = en;
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done && k < budget) begin
      tick();
      k++;
    end
    chk("done_seen", 32'(done), 1);
    tick();
  endtask

  task automatic cmp_log(input string tag);
    chk({tag, "_nreads"}, lb.size(), eb.size());
    for (int i = 0; i < eb.size() && i < lb.size(); i++) begin
      chk($sformatf("%s_bank%0d", tag, i), lb[i], eb[i]);
      chk($sformatf("%s_addr%0d", tag, i), la[i], ea[i]);
    end
  endtask

  task automatic exp_all4;
    eb.delete();
    ea.delete();
    for (int i = 0; i < 4 * BST; i++) begin
      eb.push_back(i % 4);
      ea.push_back(2 * (i / 4));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

  initial begin
    tick(2);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_bad", 32'(bad), 0);
    chk("rst_err", 32'(err_cnt), 0);
    chk("rst_tmo", 32'(timeout), 0);
    chk("rst_rd", 32'(rd), 0);
    chk("rst_addr", 32'(a0 | a1 | a2 | a3), 0);
    rst = 0;
    tick();

    // all four banks, clean data
    kick(4'hf);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_rd_t1", 32'(rd), 0);
    tick();
    chk("t1_rd_t2", 32'(rd), 32'h1);
    wait_done(400);
    exp_all4();
    cmp_log("t1");
    chk("t1_ndone", n_done, 1);
    chk("t1_bad", 32'(bad), 0);
    chk("t1_err", 32'(err_cnt), 0);
    chk("t1_busy_end", 32'(busy), 0);

    // bank 2 only, third read corrupted
    rst = 1;
    tick();
    rst = 0;
    corrupt = 3;
    kick(4'b0100);
    wait_done(300);
    corrupt = -1;
    eb = '{2, 2, 2, 2};
    ea = '{0, 2, 4, 6};
    cmp_log("t2");
    chk("t2_err", 32'(err_cnt), 1);
    chk("t2_bad", 32'(bad), 1);
    chk("t2_tmo", 32'(timeout), 0);

    // bank 1 never returns rdy
    nordy = 1;
    kick(4'b0011);
    chk("t3_bad_sticky", 32'(bad), 1);
    chk("t3_err_clr", 32'(err_cnt), 0);
    wait_done(600);
    nordy = -1;
    eb = '{0, 1, 0, 1, 0, 1, 0, 1};
    ea = '{0, 0, 2, 2, 4, 4, 6, 6};
    cmp_log("t3");
    chk("t3_err", 32'(err_cnt), BST);
    chk("t3_tmo", 32'(timeout), 1);
    chk("t3_bad", 32'(bad), 1);
    chk("t3_ndone", n_done, 1);

    // empty mask, start in DONE, start while halted
    kick(4'b0000);
    chk("t4_busy_t1", 32'(busy), 1);
    chk("t4_rd_t1", 32'(rd), 0);
    start = 1;
    tick();
    chk("t4_done_t2", 32'(done), 1);
    chk("t4_busy_t2", 32'(busy), 0);
    tick();
    start = 0;
    chk("t4_busy_t3", 32'(busy), 0);
    chk("t4_done_t3", 32'(done), 0);
    chk("t4_ndone", n_done, 1);
    chk("t4_nreads", lb.size(), 0);
    halt = 1;
    kick(4'hf);
    tick(3);
    chk("t4_halt_busy", 32'(busy), 0);
    chk("t4_halt_reads", lb.size(), 0);
    halt = 0;

    // ack+rdy together on bank 3, spurious ba3_rdy in bank 0 wait
    ack_d[0] = 1;
    rdy_d[0] = 4;
    ack_d[3] = 0;
    rdy_d[3] = 0;
    spur = 1;
    kick(4'b1001);
    wait_done(300);
    spur = 0;
    eb = '{3, 0, 3, 0, 3, 0, 3, 0};
    ea = '{0, 8, 2, 10, 4, 12, 6, 14};
    cmp_log("t5");
    chk("t5_err", 32'(err_cnt), 0);

    // reset while ba2_rd is held
    ack_d[2] = 1000;
    rdy_d[2] = 1000;
    kick(4'b0100);
    tick();
    chk("t6_rd2", 32'(rd), 32'h4);
    rst = 1;
    tick();
    chk("t6_rd_rst", 32'(rd), 0);
    chk("t6_busy_rst", 32'(busy), 0);
    chk("t6_a2_rst", 32'(a2), 0);
    chk("t6_a0_rst", 32'(a0), 0);
    chk("t6_bad_rst", 32'(bad), 0);
    rst = 0;
    ack_d = '{2, 2, 2, 2};
    rdy_d = '{5, 5, 5, 5};
    kick(4'hf);
    tick();
    chk("t6_first_rd", 32'(rd), 32'h1);
    chk("t6_first_addr", 32'(a0), 0);
    wait_done(400);
    exp_all4();
    cmp_log("t6");
    chk("t6_err", 32'(err_cnt), 0);

    chk("multi_rd", n_multi, 0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
